// File: rtl/y86_regfile_wb.sv
// Y86-64 architectural register file with write-back destination decode, halt tracking and commit counter.
// Latency: reads are combinational (optional same-cycle forwarding); writes, dbg_data and counters update on the next clk edge.
// Backpressure: wb_stall holds the W-stage instruction (no write, no count) until the first unstalled edge.
//
// Ports:
//   clk, reset              : clock and synchronous active-high reset
//   wb_valid, wb_stall      : W-stage occupancy and stall
//   icode, rA, rB, cnd      : W-stage instruction fields used for destination decode
//   valE, valM              : ALU result and memory read data to be written back
//   srcA/rdA, srcB/rdB      : decode-stage combinational read ports
//   dbg_sel/dbg_data        : registered debug read port (never forwarded)
//   halted, commit_cnt      : halt state and committed-instruction count
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle commit data onto rdA/rdB.

module y86_regfile_wb #(
    parameter int DATA_W        = 64,
    parameter int NREGS         = 15,
    parameter int ADDR_W        = 4,
    parameter int RSP_IDX       = 4,
    parameter int RESET_INDEXED = 1,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic              wb_stall,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [ADDR_W-1:0] srcA,
    input  logic [ADDR_W-1:0] srcB,
    output logic [DATA_W-1:0] rdA,
    output logic [DATA_W-1:0] rdB,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              halted,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam logic [ADDR_W-1:0] RNONE   = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] RSP     = ADDR_W'(RSP_IDX);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] dst_e;
    logic [ADDR_W-1:0] dst_m;
    logic              commit;

    // Only indices below NREGS name real registers; everything above
    // (RNONE included) reads as zero and is never written.
    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return (32'(idx) < NREGS);
    endfunction

    assign halted = (state_q == ST_HALTED);
    assign commit = wb_valid & ~wb_stall & ~halted;

    // Destination decode for the W-stage instruction.
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            I_CMOV:                 dst_e = cnd ? rB : RNONE;
            I_IRMOV, I_OPQ:         dst_e = rB;
            I_MRMOV:                dst_m = rA;
            I_CALL, I_RET, I_PUSH:  dst_e = RSP;
            I_POP: begin
                dst_e = RSP;
                dst_m = rA;
            end
            default: begin
                dst_e = RNONE;
                dst_m = RNONE;
            end
        endcase
    end

    // Halt FSM: a committed halt instruction parks the file until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (commit && (icode == I_HALT)) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Register array. When both write ports hit the same index (popq %rsp)
    // the memory value wins, so the M check comes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (RESET_INDEXED != 0) ? DATA_W'(i) : '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dst_m == ADDR_W'(i)) begin
                    regs[i] <= valM;
                end else if (dst_e == ADDR_W'(i)) begin
                    regs[i] <= valE;
                end
            end
        end
    end

    // Commit counter; counts halt and nop too, frozen once halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt <= '0;
        end else if (commit) begin
            commit_cnt <= commit_cnt + CNT_W'(1);
        end
    end

    // Debug port samples pre-edge array contents; it is never forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= in_range(dbg_sel) ? regs[dbg_sel] : '0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding; M beats E to match the write priority.
    // The in_range guard keeps an RNONE read from picking up RNONE "writes".
    always_comb begin
        if (commit && in_range(dst_m) && (srcA == dst_m)) begin
            rdA = valM;
        end else if (commit && in_range(dst_e) && (srcA == dst_e)) begin
            rdA = valE;
        end else begin
            rdA = in_range(srcA) ? regs[srcA] : '0;
        end

        if (commit && in_range(dst_m) && (srcB == dst_m)) begin
            rdB = valM;
        end else if (commit && in_range(dst_e) && (srcB == dst_e)) begin
            rdB = valE;
        end else begin
            rdB = in_range(srcB) ? regs[srcB] : '0;
        end
    end
`else
    // Array contents only; the pipeline forwarding unit covers the hazard.
    always_comb begin
        rdA = in_range(srcA) ? regs[srcA] : '0;
        rdB = in_range(srcB) ? regs[srcB] : '0;
    end
`endif

endmodule
